// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte with odd parity and checks the device acknowledge.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES) + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQUEST,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_ACK,
      S_RECOVER
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_clk_s1, r_clk_s2, r_clk_prev;
   logic               r_data_s1, r_data_s2;
   logic [7:0]         r_shift, w_shift_nxt;
   logic               r_parity, w_parity_nxt;
   logic [2:0]         r_bit_idx, w_bit_nxt;
   logic [INH_W-1:0]   r_inh_cnt, w_inh_nxt;
   logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_nxt;
   logic               r_clk_oe, w_clk_oe_nxt;
   logic               r_data_oe, w_data_oe_nxt;
   logic               r_done, w_done_nxt;
   logic               r_error, w_error_nxt;
   logic               r_ready, r_busy;
   logic               w_fall;
   logic               w_tmo_state;
   logic               w_tmo_hit;

   // Two-flop synchronizers plus previous-value flop for clock edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_data_s1  <= 1'b1;
         r_data_s2  <= 1'b1;
      end else begin
         r_clk_s1   <= ps2_clk_in;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_data_s1  <= ps2_data_in;
         r_data_s2  <= r_data_s1;
      end
   end

   assign w_fall      = r_clk_prev & ~r_clk_s2;
   assign w_tmo_state = (r_state == S_REQUEST) || (r_state == S_DATA) ||
                        (r_state == S_PARITY)  || (r_state == S_STOP) ||
                        (r_state == S_RECOVER);
   assign w_tmo_hit   = w_tmo_state && !w_fall &&
                        (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_parity_nxt  = r_parity;
      w_bit_nxt     = r_bit_idx;
      w_inh_nxt     = r_inh_cnt;
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = r_data_oe;
      w_done_nxt    = 1'b0;
      w_error_nxt   = 1'b0;
      w_tmo_nxt     = '0;

      case (r_state)
         S_IDLE: begin
            w_data_oe_nxt = 1'b0;
            if (tx_valid && r_ready) begin
               w_shift_nxt  = tx_data;
               w_parity_nxt = ~^tx_data;
               w_bit_nxt    = 3'd0;
               w_inh_nxt    = '0;
               w_clk_oe_nxt = 1'b1;
               w_state_nxt  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            w_clk_oe_nxt  = 1'b1;
            w_data_oe_nxt = 1'b0;
            if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
               w_data_oe_nxt = 1'b1;
               w_state_nxt   = S_REQUEST;
            end else begin
               w_inh_nxt = r_inh_cnt + 1'b1;
            end
         end
         S_REQUEST: begin
            w_data_oe_nxt = 1'b1;
            if (w_fall) begin
               w_data_oe_nxt = ~r_shift[0];
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               w_bit_nxt     = 3'd0;
               w_state_nxt   = S_DATA;
            end
         end
         S_DATA: begin
            if (w_fall) begin
               if (r_bit_idx == 3'd7) begin
                  w_data_oe_nxt = ~r_parity;
                  w_state_nxt   = S_PARITY;
               end else begin
                  w_data_oe_nxt = ~r_shift[0];
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_bit_nxt     = r_bit_idx + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (w_fall) begin
               w_data_oe_nxt = 1'b0;
               w_state_nxt   = S_STOP;
            end
         end
         S_STOP: begin
            w_data_oe_nxt = 1'b0;
            if (w_fall) begin
               if (!r_data_s2) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_ACK;
               end else begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = S_RECOVER;
               end
            end
         end
         S_ACK: begin
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = S_RECOVER;
         end
         S_RECOVER: begin
            w_data_oe_nxt = 1'b0;
            if (r_clk_s2 && r_data_s2) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
         end
      endcase

      // Stalled device: release the bus; RECOVER has already reported the outcome
      if (w_tmo_hit) begin
         w_state_nxt   = S_IDLE;
         w_clk_oe_nxt  = 1'b0;
         w_data_oe_nxt = 1'b0;
         w_done_nxt    = 1'b0;
         w_error_nxt   = (r_state != S_RECOVER);
      end

      if (w_tmo_state && !w_fall && (w_state_nxt == r_state)) begin
         w_tmo_nxt = r_tmo_cnt + 1'b1;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_bit_idx <= '0;
         r_inh_cnt <= '0;
         r_tmo_cnt <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_parity  <= w_parity_nxt;
         r_bit_idx <= w_bit_nxt;
         r_inh_cnt <= w_inh_nxt;
         r_tmo_cnt <= w_tmo_nxt;
         r_clk_oe  <= w_clk_oe_nxt;
         r_data_oe <= w_data_oe_nxt;
         r_done    <= w_done_nxt;
         r_error   <= w_error_nxt;
         r_ready   <= (w_state_nxt == S_IDLE);
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign tx_ready    = r_ready;
   assign busy        = r_busy;
   assign ps2_clk_oe  = r_clk_oe;
   assign ps2_data_oe = r_data_oe;
   assign done        = r_done;
   assign error       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host, and expected frames/outcomes queued at stimulus time are checked on output.
module tb_ps2_host_tx;

   localparam int unsigned INH  = 40;
   localparam int unsigned TMO  = 300;
   localparam int unsigned HALF = 12;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
   logic       dev_clk_low, dev_data_low;
   logic       ps2_clk_in, ps2_data_in;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          n_done = 0;
   int          n_err = 0;
   int          pulse_cyc = 0;
   logic [1:0]  pulse_oe = 2'b00;
   logic [10:0] exp_frame_q[$];
   bit          exp_ack_q[$];
   bit          mon_exp;
   logic [10:0] rx;

   // Open-drain bus: a line is low when either side drives it
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every done/error pulse is matched against the oldest queued outcome
   always @(negedge clk) begin
      if (done || error) begin
         pulse_cyc = cyc;
         pulse_oe  = {ps2_clk_oe, ps2_data_oe};
         if (done)  n_done++;
         if (error) n_err++;
         if (exp_ack_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, done, error}, 32'd0);
         end else begin
            mon_exp = exp_ack_q.pop_front();
            check("outcome", {30'd0, done, error}, mon_exp ? 32'd2 : 32'd1);
         end
      end
   end

   task automatic offer(input logic [7:0] d);
      bit acc;
      acc      = 1'b0;
      tx_data  = d;
      tx_valid = 1'b1;
      for (int k = 0; k < 400 && !acc; k++) begin
         @(negedge clk);
         acc = tx_ready;
         @(posedge clk); #1;
      end
      tx_valid = 1'b0;
      check("accept", 32'(acc), 32'd1);
   endtask

   task automatic dev_frame(input bit ack, input int stop_after, output int fall_cyc);
      int inh_n, req_n;
      bit seen;
      inh_n = 0; req_n = 0; seen = 1'b0; fall_cyc = 0;
      for (int k = 0; k < int'(INH) + 400 && !seen; k++) begin
         @(negedge clk);
         if (ps2_clk_oe && !ps2_data_oe) inh_n++;
         if (ps2_clk_oe && ps2_data_oe)  req_n++;
         if (!ps2_clk_oe && ps2_data_oe) seen = 1'b1;
      end
      check("request_seen", 32'(seen), 32'd1);
      if (!seen) return;
      check("inhibit_len", inh_n, INH);
      check("request_hold", req_n, 32'd1);
      rx    = '1;
      rx[0] = ps2_data_in;
      @(posedge clk); #1;
      repeat (HALF) @(posedge clk);
      #1;
      for (int p = 1; p <= 11; p++) begin
         if (p == 11) begin
            dev_data_low = ack;
            repeat (HALF) @(posedge clk);
            #1;
         end
         dev_clk_low = 1'b1;
         fall_cyc    = cyc;
         repeat (HALF) @(posedge clk);
         #1;
         dev_clk_low = 1'b0;
         if (p <= 10) rx[p] = ps2_data_in;
         repeat (HALF) @(posedge clk);
         #1;
         if (p == stop_after) return;
      end
      dev_data_low = 1'b0;
      if (exp_frame_q.size() == 0) check("frame_unexpected", 32'(rx), 32'd0);
      else                         check("frame_bits", 32'(rx), 32'(exp_frame_q.pop_front()));
   endtask

   task automatic wait_idle(input string tag);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < int'(TMO) + 400 && !ok; k++) begin
         @(negedge clk);
         ok = !busy;
      end
      check(tag, 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] d, input bit ack);
      int fc, d0, e0;
      d0 = n_done; e0 = n_err;
      exp_frame_q.push_back({1'b1, ~^d, d, 1'b0});
      exp_ack_q.push_back(ack);
      offer(d);
      check("busy_in_frame", {busy, tx_ready}, 32'd2);
      dev_frame(ack, 0, fc);
      wait_idle("idle_after_frame");
      check("done_count", n_done - d0, ack ? 32'd1 : 32'd0);
      check("error_count", n_err - e0, ack ? 32'd0 : 32'd1);
   endtask

   initial begin
      int fc, d0, e0;
      bit acc;
      reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      dev_clk_low = 1'b0; dev_data_low = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("rst_pulses", {done, error}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      send(8'hED, 1'b1);
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      send(8'h01, 1'b1);
      send(8'hA7, 1'b0);

      // Device stops clocking after the fourth fall
      e0 = n_err;
      exp_ack_q.push_back(1'b0);
      offer(8'h96);
      dev_frame(1'b1, 4, fc);
      for (int k = 0; k < int'(TMO) + 100 && n_err == e0; k++) @(negedge clk);
      check("timeout_seen", n_err - e0, 32'd1);
      check("timeout_latency", pulse_cyc - fc, TMO + 3);
      check("timeout_release", 32'(pulse_oe), 32'd0);
      wait_idle("idle_after_timeout");

      // Reset while bit 3 is on the line
      d0 = n_done + n_err;
      offer(8'hA5);
      dev_frame(1'b1, 4, fc);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("midrst_ready", {tx_ready, busy}, 32'd2);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("midrst_no_pulse", n_done + n_err - d0, 32'd0);
      send(8'hF4, 1'b1);

      // tx_valid held with new data during a frame
      d0 = n_done;
      exp_frame_q.push_back({1'b1, ~^8'h5A, 8'h5A, 1'b0});
      exp_ack_q.push_back(1'b1);
      offer(8'h5A);
      exp_frame_q.push_back({1'b1, ~^8'h3C, 8'h3C, 1'b0});
      exp_ack_q.push_back(1'b1);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      dev_frame(1'b1, 0, fc);
      acc = 1'b0;
      for (int k = 0; k < 400 && !acc; k++) begin
         @(negedge clk);
         acc = tx_ready;
         @(posedge clk); #1;
      end
      tx_valid = 1'b0;
      check("second_accept", 32'(acc), 32'd1);
      check("first_done_before_second", n_done - d0, 32'd1);
      dev_frame(1'b1, 0, fc);
      wait_idle("idle_after_second");
      check("held_done_count", n_done - d0, 32'd2);

      check("scoreboard_empty", exp_ack_q.size() + exp_frame_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
